im_cached_param: RTL and testbench
==================================

# im_cached_param

Parametrised, read-only, direct-mapped instruction cache with multi-word lines and a sequential line-refill engine. It is the next generation of the single-word instruction cache. It sits between the fetch stage (address in, hit/data out) and a slow instruction memory that it drives through an explicit request/ready handshake. The memory is instantiated outside this block. It adds configurable depth and line size, asynchronous reset, and a flush command.

## Interface
- NLINES, 4: number of cache lines; power of two, ≥2.
- WORDS_PER_LINE, 2: 32-bit words per line; power of two, ≥1.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- addr  in  32  fetch byte address; bits [1:0] ignored.
- flush  in  1  invalidate all lines; single-cycle pulse.
- hit  out  1  data valid for addr this cycle.
- data  out  32  instruction word; 32'h0 whenever hit=0.
- busy  out  1  refill engine active (state ≠ IDLE).
- mem_req  out  1  memory read request.
- mem_addr  out  32  word-aligned memory address.
- mem_rdy  in  1  memory word valid this cycle.
- mem_data  in  32  memory read data.

## Operation
- Address split: [1:0] byte, then OW=log2(WORDS_PER_LINE) word-offset bits, then IW=log2(NLINES) index bits, then tag = the remaining upper bits (32−2−OW−IW).
- Per line: valid bit, tag, WORDS_PER_LINE data words.
- hit = (state==IDLE) && valid[index] && tag match. It is combinational, and data is the selected word.
- FSM states:
  - IDLE: on a miss with flush low, latch line base = addr with the low 2+OW bits cleared, clear word_cnt, and go to FILL.
  - FILL: mem_req=1 and mem_addr = base + 4·word_cnt. On a clk edge with mem_rdy=1, write mem_data into word word_cnt of the latched index and increment word_cnt. On the last word, go to IDLE.
- On leaving FILL, set the latched line's valid and tag. If a flush is pending, leave that line invalid and clear the pending flag instead.
- A refill is never aborted. addr may change during FILL. The refill completes for the latched line, and hit stays 0 until IDLE.
- flush in IDLE clears all valid bits at the next edge. No refill starts that cycle, and hit is forced 0 while flush=1.
- flush in FILL sets flush_pending and clears all other valid bits at the edge. The in-flight line is not validated.
- Refill writes land in the latched index only. Other lines are untouched.

## Timing
- Reset (async assert): state=IDLE, all valid=0, word_cnt=0, flush_pending=0, mem_req=0, mem_addr=0, busy=0, hit=0, data=0. Data/tag arrays are not reset.
- Hit latency: 0 cycles (combinational from addr).
- Miss penalty is 1 + Σ(per-word memory latency) cycles until hit. Example: miss seen at cycle 0, FILL from cycle 1. With mem_rdy on the first FILL cycle of each word, the state is IDLE at cycle 1+WORDS_PER_LINE and hit=1 that cycle if addr is unchanged.
- mem_addr is stable while mem_req=1 and mem_rdy=0. It advances on the edge where mem_rdy is sampled high.
- mem_rdy is ignored when mem_req=0.
- rst_n assertion mid-FILL drops mem_req immediately. The partially filled line stays invalid.

## Configuration
- ICACHE_STATS_EN defined: adds outputs hit_count[31:0] and miss_count[31:0], both reset to 0 and wrapping at 2^32.
  - hit_count increments on each edge with hit=1 and flush=0.
  - miss_count increments on each IDLE→FILL transition.
- ICACHE_STATS_EN undefined: those ports and counters do not exist, and behaviour is otherwise identical.

## Structure
- Shared package `icache_pkg` holds:
  - the state enum (IDLE, FILL);
  - the address-field width functions (OW, IW, tag width);
  - the constant WORD_BYTES=4.
- One sub-module, `icache_line_store`:
  - holds the valid/tag/data arrays;
  - one combinational read port (index, word offset);
  - one write port (index, word offset, data);
  - a set-valid/tag strobe and a clear-all-valid strobe.
- The FSM, counters and flush logic stay in im_cached_param.

## Test plan
All scenarios use NLINES=4, WORDS_PER_LINE=2 and a memory model with programmable latency.
- Reset, then addr=0x0000_0010 → hit=0 and data=0. One cycle later mem_req=1 with mem_addr=0x10, then 0x14. After the fill, hit=1 and data=mem[0x10]. Then addr=0x14 → hit=1 in the same cycle.
- Conflict: fill 0x10, then addr=0x30 (same index 2, different tag) → miss, refill from 0x30/0x34. Then addr=0x10 → miss again.
- Memory latency 3 cycles per word: mem_addr holds 0x30 for three cycles, and the miss penalty is 1+6=7 cycles.
- flush pulsed during FILL of 0x08 → after the fill, hit=0 for 0x08 and for previously cached 0x10, and new refills occur.
- rst_n low mid-FILL → mem_req=0 and busy=0 immediately. After release, addr of the partially filled line misses.
- With ICACHE_STATS_EN defined: 3 misses, then 5 hit cycles → miss_count=3 and hit_count=5.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and address-field helpers for the parametrised instruction cache.
package icache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  localparam int unsigned WORD_BYTES = 4;

  function automatic int unsigned off_width(input int unsigned words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int unsigned idx_width(input int unsigned nlines);
    return $clog2(nlines);
  endfunction

  function automatic int unsigned tag_width(input int unsigned nlines,
                                            input int unsigned words_per_line);
    return 32 - 2 - off_width(words_per_line) - idx_width(nlines);
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data storage for the direct-mapped cache: one combinational read port,
// one word write port, a per-line valid/tag strobe and a clear-all-valid strobe.
module icache_line_store #(
  parameter int unsigned NLINES         = 4,
  parameter int unsigned WORDS_PER_LINE = 2,
  parameter int unsigned IW             = 2,
  parameter int unsigned OWS            = 1,
  parameter int unsigned TW             = 27
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [IW-1:0]  rd_idx_i,
  input  logic [OWS-1:0] rd_off_i,
  output logic           rd_valid_o,
  output logic [TW-1:0]  rd_tag_o,
  output logic [31:0]    rd_data_o,
  input  logic           wr_en_i,
  input  logic [IW-1:0]  wr_idx_i,
  input  logic [OWS-1:0] wr_off_i,
  input  logic [31:0]    wr_data_i,
  input  logic           tag_set_i,
  input  logic [IW-1:0]  tag_idx_i,
  input  logic [TW-1:0]  tag_i,
  input  logic           valid_i,
  input  logic           clr_all_i
);

  logic [NLINES-1:0] valid_q;
  logic [TW-1:0]     tag_q  [NLINES];
  logic [31:0]       data_q [NLINES][WORDS_PER_LINE];

  // A per-line strobe issued together with clear-all takes effect afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      if (clr_all_i) valid_q <= '0;
      if (tag_set_i) valid_q[tag_idx_i] <= valid_i;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i)   data_q[wr_idx_i][wr_off_i] <= wr_data_i;
    if (tag_set_i) tag_q[tag_idx_i] <= tag_i;
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i][rd_off_i];

endmodule

// File: rtl/im_cached_param.sv
// Direct-mapped read-only instruction cache with multi-word lines and a sequential refill engine.
// Define ICACHE_STATS_EN to add hit_count/miss_count statistics outputs.
module im_cached_param
  import icache_pkg::*;
#(
  parameter int unsigned NLINES         = 4,
  parameter int unsigned WORDS_PER_LINE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic        flush,
  output logic        hit,
  output logic [31:0] data,
  output logic        busy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rdy,
  input  logic [31:0] mem_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int unsigned OW  = off_width(WORDS_PER_LINE);
  localparam int unsigned IW  = idx_width(NLINES);
  localparam int unsigned TW  = tag_width(NLINES, WORDS_PER_LINE);
  localparam int unsigned OWS = (OW == 0) ? 1 : OW;
  localparam logic [31:0] LINE_MASK = ~(32'(WORDS_PER_LINE * WORD_BYTES) - 32'd1);

  state_e         state_q, state_d;
  logic [OWS-1:0] word_cnt_q, word_cnt_d;
  logic [31:0]    base_q, base_d;
  logic           flush_pend_q, flush_pend_d;

  logic [IW-1:0]  cur_idx, fill_idx;
  logic [OWS-1:0] cur_off;
  logic [TW-1:0]  cur_tag, fill_tag;
  logic           rd_valid;
  logic [TW-1:0]  rd_tag;
  logic [31:0]    rd_data;
  logic           lookup_hit, last_word;
  logic           tag_set, valid_set, wr_en;

  assign cur_off  = (OW == 0) ? '0 : OWS'(addr >> 2);
  assign cur_idx  = IW'(addr >> (2 + OW));
  assign cur_tag  = TW'(addr >> (2 + OW + IW));
  assign fill_idx = IW'(base_q >> (2 + OW));
  assign fill_tag = TW'(base_q >> (2 + OW + IW));

  assign lookup_hit = rd_valid && (rd_tag == cur_tag);
  assign hit        = (state_q == IDLE) && !flush && lookup_hit;
  assign data       = hit ? rd_data : '0;
  assign busy       = (state_q == FILL);
  assign last_word  = (word_cnt_q == OWS'(WORDS_PER_LINE - 1));
  assign wr_en      = (state_q == FILL) && mem_rdy;

  // The target line is invalidated when its refill starts, so a flush or reset
  // during FILL can never leave stale data marked valid under the old tag.
  icache_line_store #(
    .NLINES        (NLINES),
    .WORDS_PER_LINE(WORDS_PER_LINE),
    .IW            (IW),
    .OWS           (OWS),
    .TW            (TW)
  ) u_store (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx_i  (cur_idx),
    .rd_off_i  (cur_off),
    .rd_valid_o(rd_valid),
    .rd_tag_o  (rd_tag),
    .rd_data_o (rd_data),
    .wr_en_i   (wr_en),
    .wr_idx_i  (fill_idx),
    .wr_off_i  (word_cnt_q),
    .wr_data_i (mem_data),
    .tag_set_i (tag_set),
    .tag_idx_i ((state_q == IDLE) ? cur_idx : fill_idx),
    .tag_i     ((state_q == IDLE) ? cur_tag : fill_tag),
    .valid_i   (valid_set),
    .clr_all_i (flush)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      word_cnt_q   <= '0;
      base_q       <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_cnt_q   <= word_cnt_d;
      base_q       <= base_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    word_cnt_d   = word_cnt_q;
    base_d       = base_q;
    flush_pend_d = flush_pend_q;
    tag_set      = 1'b0;
    valid_set    = 1'b0;
    mem_req      = 1'b0;
    mem_addr     = '0;
    unique case (state_q)
      IDLE: begin
        if (!flush && !lookup_hit) begin
          state_d    = FILL;
          base_d     = addr & LINE_MASK;
          word_cnt_d = '0;
          tag_set    = 1'b1;
        end
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = base_q | (32'(word_cnt_q) << 2);
        if (flush) flush_pend_d = 1'b1;
        if (mem_rdy) begin
          word_cnt_d = word_cnt_q + 1'b1;
          if (last_word) begin
            state_d      = IDLE;
            tag_set      = 1'b1;
            valid_set    = !(flush_pend_q || flush);
            flush_pend_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (state_q == IDLE && state_d == FILL) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_im_cached_param.sv
// Self-checking bench for im_cached_param (NLINES=4, WORDS_PER_LINE=2) with a latency-programmable
// memory model and a line-address reference model; checks stats outputs when ICACHE_STATS_EN is defined.
module tb_im_cached_param;

  localparam int unsigned NL  = 4;
  localparam int unsigned WPL = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic        flush;
  logic        hit;
  logic [31:0] data;
  logic        busy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rdy;
  logic [31:0] mem_data;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned lat = 1;
  int unsigned wcnt = 0;

  // Reference model: each line remembers the base address it holds.
  bit          m_valid [NL];
  logic [31:0] m_base  [NL];
  bit          m_busy, m_flushed, last_hit;
  logic [31:0] m_fill;
  int unsigned m_done, m_hits, m_misses;

  im_cached_param #(.NLINES(NL), .WORDS_PER_LINE(WPL)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr    (addr),
    .flush   (flush),
    .hit     (hit),
    .data    (data),
    .busy    (busy),
    .mem_req (mem_req),
    .mem_addr(mem_addr),
    .mem_rdy (mem_rdy),
    .mem_data(mem_data)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic int unsigned lidx(input logic [31:0] a);
    return (a / (WPL * 4)) % NL;
  endfunction

  function automatic logic [31:0] lbase(input logic [31:0] a);
    return a - (a % (WPL * 4));
  endfunction

  // Memory: answers after 'lat' cycles of a held request; toggles mem_rdy randomly while idle.
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_rdy  = 1'b0;
      mem_data = '0;
      wcnt     = 0;
    end else if (mem_req) begin
      wcnt++;
      if (wcnt >= lat) begin
        mem_rdy  = 1'b1;
        mem_data = memf(mem_addr);
        wcnt     = 0;
      end else begin
        mem_rdy  = 1'b0;
        mem_data = $urandom;
      end
    end else begin
      mem_rdy  = 1'($urandom_range(0, 1));
      mem_data = $urandom;
      wcnt     = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    m_busy = 1'b0; m_flushed = 1'b0; m_done = 0;
    m_hits = 0; m_misses = 0;
  endtask

  task automatic step(input logic [31:0] a, input logic f);
    bit exp_hit;
    @(negedge clk);
    addr  = a;
    flush = f;
    #1;
    exp_hit = !m_busy && !f && m_valid[lidx(a)] && (m_base[lidx(a)] == lbase(a));
    last_hit = hit;
    check("hit", 32'(hit), 32'(exp_hit));
    check("data", data, exp_hit ? memf(a & ~32'h3) : 32'h0);
    check("busy", 32'(busy), 32'(m_busy));
    check("mem_req", 32'(mem_req), 32'(m_busy));
    check("mem_addr", mem_addr, m_busy ? m_fill + 32'(m_done * 4) : 32'h0);
`ifdef ICACHE_STATS_EN
    check("hit_count", hit_count, m_hits);
    check("miss_count", miss_count, m_misses);
`endif
    if (exp_hit) m_hits++;
    if (f) for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    if (m_busy) begin
      if (f) m_flushed = 1'b1;
      if (mem_rdy) begin
        m_done++;
        if (m_done == WPL) begin
          m_busy = 1'b0;
          if (!m_flushed) begin
            m_valid[lidx(m_fill)] = 1'b1;
            m_base[lidx(m_fill)]  = m_fill;
          end
          m_flushed = 1'b0;
        end
      end
    end else if (!f && !exp_hit) begin
      m_busy = 1'b1;
      m_fill = lbase(a);
      m_done = 0;
      m_valid[lidx(a)] = 1'b0;
      m_misses++;
    end
  endtask

  task automatic run_until_hit(input logic [31:0] a, output int unsigned n);
    n = 0;
    step(a, 1'b0);
    while (!last_hit && n < 50) begin
      n++;
      step(a, 1'b0);
    end
  endtask

  initial begin
    int unsigned n;
    logic [31:0] ra;
    rst_n = 1'b0;
    addr  = '0;
    flush = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_hit", 32'(hit), 32'h0);
    check("rst_data", data, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic fill, then neighbouring word of the same line.
    run_until_hit(32'h10, n);
    check("penalty_lat1", n, 3);
    step(32'h14, 1'b0);
    check("hit_0x14", 32'(last_hit), 32'h1);

    // Conflict on index 2 with 3-cycle memory latency.
    lat = 3;
    run_until_hit(32'h30, n);
    check("penalty_lat3", n, 7);
    lat = 1;
    run_until_hit(32'h10, n);
    check("conflict_refill", n, 3);

    // Flush during a refill of 0x08.
    step(32'h08, 1'b0);
    step(32'h08, 1'b1);
    step(32'h08, 1'b0);
    step(32'h10, 1'b0);
    check("flushed_0x10_miss", 32'(last_hit), 32'h0);
    run_until_hit(32'h10, n);
    check("refill_after_flush", n, 2);

    // Asynchronous reset in the middle of a refill.
    lat = 3;
    step(32'h40, 1'b0);
    step(32'h40, 1'b0);
    @(posedge clk);
    #2;
    flush = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midfill_rst_req", 32'(mem_req), 32'h0);
    check("midfill_rst_busy", 32'(busy), 32'h0);
    check("midfill_rst_hit", 32'(hit), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    lat = 1;
    step(32'h40, 1'b0);
    check("partial_line_miss", 32'(last_hit), 32'h0);

    // Randomised traffic with locality, random flushes and latencies.
    ra = 32'h40;
    repeat (600) begin
      int unsigned r;
      lat = $urandom_range(1, 3);
      r = $urandom_range(0, 3);
      if (r == 2) ra = (ra + 32'h4) & 32'h7F;
      else if (r == 3) ra = 32'($urandom_range(0, 127));
      step(ra, $urandom_range(0, 19) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
